// File: rtl/telem_rx.sv
// telem_rx: 8N1 UART receiver and 8-byte telemetry packet framer.
// Publishes battery, current and torque words after each complete packet
// and keeps a saturating count of framing, format and gap-timeout errors.
module telem_rx #(
   parameter int unsigned BAUD_DIV = 2604,
   parameter int unsigned GAP_BITS = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX,
   output logic [11:0] batt,
   output logic [11:0] curr,
   output logic [11:0] torque,
   output logic        pkt_vld,
   output logic [7:0]  err_cnt,
   output logic        busy
);

   localparam logic [11:0] HALF_LD = 12'(BAUD_DIV / 2 - 1);
   localparam logic [11:0] FULL_LD = 12'(BAUD_DIV - 1);
   localparam logic [15:0] GAP_LIM = 16'(GAP_BITS * BAUD_DIV);

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_st_e;
   typedef enum logic [2:0] {P_HUNT_AA, P_HUNT_55, P_B_HI, P_B_LO,
                             P_C_HI, P_C_LO, P_T_HI, P_T_LO} pkt_st_e;

   logic       rx_m_q, rx_s_q;
   byte_st_e   bst_q, bst_d;
   logic [11:0] cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] sh_q, sh_d;
   logic       wait_hi_q, wait_hi_d;
   logic       rdy_q, rdy_d;
   logic       tick, frame_err;

   pkt_st_e    pst_q, pst_d;
   logic [11:0] shb_q, shb_d, shc_q, shc_d, sht_q, sht_d;
   logic [11:0] batt_q, batt_d, curr_q, curr_d, torque_q, torque_d;
   logic       vld_q, vld_d;
   logic [7:0] err_q, err_d;
   logic [15:0] gap_q, gap_d;
   logic       fmt_err, tmo;

   // Two-flop synchronizer for the asynchronous RX line, preset to idle-high.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m_q <= 1'b1;
         rx_s_q <= 1'b1;
      end else begin
         rx_m_q <= RX;
         rx_s_q <= rx_m_q;
      end
   end

   // Byte FSM state and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         bst_q     <= B_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         sh_q      <= '0;
         wait_hi_q <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         bst_q     <= bst_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         sh_q      <= sh_d;
         wait_hi_q <= wait_hi_d;
         rdy_q     <= rdy_d;
      end
   end

   // Byte FSM next state: mid-bit sampling driven by a down-counting baud timer.
   // After a framing error the line must go high again before a new start bit is accepted.
   always_comb begin
      bst_d     = bst_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      sh_d      = sh_q;
      wait_hi_d = wait_hi_q;
      rdy_d     = 1'b0;
      frame_err = 1'b0;
      tick      = (cnt_q == '0);
      case (bst_q)
         B_IDLE: begin
            if (rx_s_q) wait_hi_d = 1'b0;
            if (!rx_s_q && !wait_hi_q) begin
               bst_d = B_START;
               cnt_d = HALF_LD;
            end
         end
         B_START: begin
            if (!tick) cnt_d = cnt_q - 12'd1;
            else if (rx_s_q) bst_d = B_IDLE;
            else begin
               bst_d = B_DATA;
               cnt_d = FULL_LD;
               idx_d = '0;
            end
         end
         B_DATA: begin
            if (!tick) cnt_d = cnt_q - 12'd1;
            else begin
               sh_d  = {rx_s_q, sh_q[7:1]};
               cnt_d = FULL_LD;
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) bst_d = B_STOP;
            end
         end
         B_STOP: begin
            if (!tick) cnt_d = cnt_q - 12'd1;
            else begin
               bst_d = B_IDLE;
               if (rx_s_q) rdy_d = 1'b1;
               else begin
                  frame_err = 1'b1;
                  wait_hi_d = 1'b1;
               end
            end
         end
         default: bst_d = B_IDLE;
      endcase
   end

   // Packet FSM state, shadows, visible outputs and error counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         pst_q    <= P_HUNT_AA;
         shb_q    <= '0;
         shc_q    <= '0;
         sht_q    <= '0;
         batt_q   <= '0;
         curr_q   <= '0;
         torque_q <= '0;
         vld_q    <= 1'b0;
         err_q    <= '0;
         gap_q    <= '0;
      end else begin
         pst_q    <= pst_d;
         shb_q    <= shb_d;
         shc_q    <= shc_d;
         sht_q    <= sht_d;
         batt_q   <= batt_d;
         curr_q   <= curr_d;
         torque_q <= torque_d;
         vld_q    <= vld_d;
         err_q    <= err_d;
         gap_q    <= gap_d;
      end
   end

   // Packet FSM next state: header hunt, payload capture, gap timeout, error merge.
   // sh_q still holds the received byte while rdy_q is high, so it doubles as the byte bus.
   always_comb begin
      pst_d    = pst_q;
      shb_d    = shb_q;
      shc_d    = shc_q;
      sht_d    = sht_q;
      batt_d   = batt_q;
      curr_d   = curr_q;
      torque_d = torque_q;
      vld_d    = 1'b0;
      err_d    = err_q;
      fmt_err  = 1'b0;
      tmo      = 1'b0;
      if (pst_q == P_HUNT_AA || bst_q != B_IDLE) gap_d = '0;
      else begin
         gap_d = gap_q + 16'd1;
         tmo   = (gap_q == GAP_LIM);
      end
      if (rdy_q) begin
         case (pst_q)
            P_HUNT_AA: if (sh_q == 8'hAA) pst_d = P_HUNT_55;
            P_HUNT_55: begin
               if (sh_q == 8'h55) pst_d = P_B_HI;
               else if (sh_q != 8'hAA) pst_d = P_HUNT_AA;
            end
            P_B_HI, P_C_HI, P_T_HI: begin
               if (sh_q[7:4] != 4'h0) begin
                  fmt_err = 1'b1;
                  pst_d   = P_HUNT_AA;
               end else begin
                  if (pst_q == P_B_HI) shb_d[11:8] = sh_q[3:0];
                  if (pst_q == P_C_HI) shc_d[11:8] = sh_q[3:0];
                  if (pst_q == P_T_HI) sht_d[11:8] = sh_q[3:0];
                  pst_d = pkt_st_e'(pst_q + 3'd1);
               end
            end
            P_B_LO: begin
               shb_d[7:0] = sh_q;
               pst_d      = P_C_HI;
            end
            P_C_LO: begin
               shc_d[7:0] = sh_q;
               pst_d      = P_T_HI;
            end
            P_T_LO: begin
               batt_d   = shb_q;
               curr_d   = shc_q;
               torque_d = {sht_q[11:8], sh_q};
               vld_d    = 1'b1;
               pst_d    = P_HUNT_AA;
            end
            default: pst_d = P_HUNT_AA;
         endcase
      end
      if (tmo || frame_err) pst_d = P_HUNT_AA;
      if ((tmo || frame_err || fmt_err) && err_q != 8'hFF) err_d = err_q + 8'd1;
   end

   assign batt    = batt_q;
   assign curr    = curr_q;
   assign torque  = torque_q;
   assign pkt_vld = vld_q;
   assign err_cnt = err_q;
   assign busy    = (bst_q != B_IDLE) || (pst_q != P_HUNT_AA);

endmodule

// File: tb/tb_telem_rx.sv
// Scoreboard bench for telem_rx: stimulus pushes expected packet words,
// a negedge monitor pops and compares on every pkt_vld pulse.
module tb_telem_rx;
   localparam int unsigned BD = 16;

   logic        clk = 1'b0;
   logic        rst, RX;
   logic [11:0] batt, curr, torque;
   logic        pkt_vld, busy;
   logic [7:0]  err_cnt;

   int          errors = 0;
   int          checks = 0;
   logic [35:0] exp_q[$];
   logic [35:0] last;
   logic [7:0]  exp_err;

   telem_rx #(.BAUD_DIV(BD), .GAP_BITS(20)) dut (
      .clk(clk), .rst(rst), .RX(RX), .batt(batt), .curr(curr), .torque(torque),
      .pkt_vld(pkt_vld), .err_cnt(err_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every pkt_vld cycle must match the oldest outstanding packet.
   always @(negedge clk) begin
      logic [35:0] e;
      if (pkt_vld === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pkt_unexpected: got %0h expected no pulse", {batt, curr, torque});
         end else begin
            e = exp_q.pop_front();
            if ({batt, curr, torque} !== e) begin
               errors++;
               $display("FAIL pkt_data: got %0h expected %0h", {batt, curr, torque}, e);
            end
         end
      end
   end

   task automatic drive_bit(input logic v);
      RX = v;
      repeat (BD) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
   endtask

   task automatic idle_bits(input int n);
      RX = 1'b1;
      repeat (n * BD) @(negedge clk);
   endtask

   task automatic send_pkt(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
      logic [7:0] by[8];
      by = '{8'hAA, 8'h55, {4'h0, b[11:8]}, b[7:0], {4'h0, c[11:8]}, c[7:0],
             {4'h0, t[11:8]}, t[7:0]};
      exp_q.push_back({b, c, t});
      last = {b, c, t};
      for (int i = 0; i < 8; i++) send_byte(by[i], 1'b1);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 8 * BD) begin
         @(negedge clk);
         n++;
      end
      chk(name, 36'(exp_q.size()), 36'd0);
   endtask

   initial begin
      logic [7:0] fmt_bytes[9];
      rst = 1'b1;
      RX  = 1'b1;
      last = '0;
      exp_err = 8'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_outputs", {batt, curr, torque}, 36'd0);
      chk("rst_err", 36'(err_cnt), 36'd0);
      chk("rst_vld", 36'(pkt_vld), 36'd0);
      chk("rst_busy", 36'(busy), 36'd0);
      idle_bits(2);

      // Clean packet
      send_pkt(12'hA98, 12'h123, 12'h456);
      drain("pkt1_drain");
      idle_bits(2);
      chk("pkt1_err", 36'(err_cnt), 36'(exp_err));
      chk("pkt1_busy", 36'(busy), 36'd0);

      // Back-to-back packets, no idle between them
      send_pkt(12'h111, 12'h222, 12'h333);
      send_pkt(12'hFFF, 12'h000, 12'h7FF);
      drain("b2b_drain");
      chk("b2b_final", {batt, curr, torque}, {12'hFFF, 12'h000, 12'h7FF});
      idle_bits(2);

      // Framing error on the 4th byte, then a clean packet
      send_byte(8'hAA, 1'b1);
      send_byte(8'h55, 1'b1);
      send_byte(8'h0B, 1'b1);
      send_byte(8'hCD, 1'b0);
      idle_bits(3);
      exp_err++;
      chk("frame_err", 36'(err_cnt), 36'(exp_err));
      chk("frame_hold", {batt, curr, torque}, last);
      send_pkt(12'h0C3, 12'h5A5, 12'h00F);
      drain("frame_next_drain");
      idle_bits(2);

      // AA AA 55 prefix syncs; high byte 0x1A is a format error
      fmt_bytes = '{8'hAA, 8'hAA, 8'h55, 8'h1A, 8'h22, 8'h01, 8'h33, 8'h02, 8'h44};
      for (int i = 0; i < 9; i++) send_byte(fmt_bytes[i], 1'b1);
      idle_bits(2);
      exp_err++;
      chk("fmt_err", 36'(err_cnt), 36'(exp_err));
      chk("fmt_hold", {batt, curr, torque}, last);

      // Short low glitch on idle line
      RX = 1'b0;
      repeat (5) @(negedge clk);
      chk("glitch_busy_hi", 36'(busy), 36'd1);
      RX = 1'b1;
      idle_bits(2);
      chk("glitch_busy_lo", 36'(busy), 36'd0);
      chk("glitch_err", 36'(err_cnt), 36'(exp_err));

      // Stall 25 bit-times after byte 3
      send_byte(8'hAA, 1'b1);
      send_byte(8'h55, 1'b1);
      send_byte(8'h01, 1'b1);
      chk("stall_busy", 36'(busy), 36'd1);
      idle_bits(25);
      exp_err++;
      chk("timeout_err", 36'(err_cnt), 36'(exp_err));
      chk("timeout_busy", 36'(busy), 36'd0);
      chk("timeout_hold", {batt, curr, torque}, last);

      // Reset in the middle of byte 5
      send_byte(8'hAA, 1'b1);
      send_byte(8'h55, 1'b1);
      send_byte(8'h0A, 1'b1);
      send_byte(8'h98, 1'b1);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b0);
      rst = 1'b1;
      RX  = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_err = 8'd0;
      last = '0;
      chk("midrst_outputs", {batt, curr, torque}, 36'd0);
      chk("midrst_err", 36'(err_cnt), 36'd0);
      idle_bits(25);
      chk("midrst_busy", 36'(busy), 36'd0);
      send_pkt(12'h321, 12'h654, 12'h987);
      drain("midrst_next_drain");
      idle_bits(2);
      chk("final_err", 36'(err_cnt), 36'(exp_err));
      chk("final_outputs", {batt, curr, torque}, last);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
